// File: rtl/fp_result_collector.sv
// Queues the A/B result pair emitted by double_multipler and replays it on a valid/ready port.
// Optional CLASS_FLAGS_EN adds out_class = {nan, inf, zero, denorm} stored with each entry.
module fp_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [31:0]      res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_tag,
  output logic [CNT_W-1:0] count,
  output logic             overflow
`ifdef CLASS_FLAGS_EN
  ,
  output logic [3:0]       out_class
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef CLASS_FLAGS_EN
  localparam int EW = 37;
`else
  localparam int EW = 33;
`endif

  typedef enum logic [1:0] {IDLE, CAPT_B, DROP} state_t;

  state_t           state, state_nxt;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   space;
  logic             pop, push, push_tag, set_ovf;
  logic [EW-1:0]    entry_in;

`ifdef CLASS_FLAGS_EN
  function automatic logic [3:0] classify(input logic [31:0] w);
    logic exp_ones, exp_zero, man_zero;
    exp_ones = (w[30:23] == 8'hFF);
    exp_zero = (w[30:23] == 8'h00);
    man_zero = (w[22:0] == 23'd0);
    return {exp_ones & ~man_zero, exp_ones & man_zero, exp_zero & man_zero, exp_zero & ~man_zero};
  endfunction

  assign entry_in  = {push_tag, classify(res), res};
  assign out_class = mem[rd_ptr][35:32];
`else
  assign entry_in  = {push_tag, res};
`endif

  assign out_valid = (cnt != '0);
  assign out_data  = mem[rd_ptr][31:0];
  assign out_tag   = mem[rd_ptr][EW-1];
  assign count     = cnt;
  assign pop       = out_valid & out_ready;
  // Free slots seen by the incoming burst, including the slot released by a same-cycle pop.
  assign space     = (CNT_W+1)'(DEPTH) - {1'b0, cnt} + {{CNT_W{1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_tag  = 1'b0;
    set_ovf   = 1'b0;
    case (state)
      IDLE: begin
        if (done) begin
          if (space >= (CNT_W+1)'(2)) begin
            push      = 1'b1;
            state_nxt = CAPT_B;
          end else begin
            set_ovf   = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      CAPT_B: begin
        push      = 1'b1;
        push_tag  = 1'b1;
        state_nxt = IDLE;
      end
      DROP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (set_ovf) overflow <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= entry_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
